spi_target_regs: RTL

SPI_TARGET_REGS -- requirements
Module: spi_target_regs

---
 rtl/pedal_pkg.sv | 36 +++
 rtl/spi_sync.sv | 32 +++
 rtl/spi_target_regs.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pedal_pkg.sv
// Shared constants for the pedal SPI register target:
// register map, reset values, ID and FSM encoding.
package pedal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_WAIT_CS
  } spi_state_t;

  localparam logic [6:0] ADDR_THRES = 7'd0;
  localparam logic [6:0] ADDR_SLOPE = 7'd1;
  localparam logic [6:0] ADDR_GAIN  = 7'd2;
  localparam logic [6:0] ADDR_CTRL  = 7'd3;
  localparam logic [6:0] ADDR_TRIM1 = 7'd4;
  localparam logic [6:0] ADDR_TRIM2 = 7'd5;
  localparam logic [6:0] ADDR_TRIM3 = 7'd6;
  localparam logic [6:0] ADDR_ID    = 7'd7;

  localparam logic [7:0] RST_THRES = 8'h80;
  localparam logic [7:0] RST_SLOPE = 8'h02;
  localparam logic [7:0] RST_GAIN  = 8'h40;
  localparam logic [4:0] RST_CTRL  = 5'h00;
  localparam logic [7:0] RST_TRIM  = 8'h80;
  localparam logic [7:0] ID_VALUE  = 8'hA5;

  localparam logic [4:0] LAST_CMD_BIT = 5'd7;
  localparam logic [4:0] LAST_BIT     = 5'd15;
  localparam logic [4:0] MAX_BITS     = 5'd16;

  function automatic logic is_writable(input logic [6:0] a);
    return a < ADDR_ID;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with rise/fall detection
// on the synchronized level.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-0 target with 16-bit R/nW frames onto a
// small effect-parameter register file.
module spi_target_regs
  import pedal_pkg::*;
(
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oeb_o,
  output logic [7:0] thres_o,
  output logic [7:0] slope_o,
  output logic [7:0] gain_o,
  output logic [4:0] ctrl_o,
  output logic [7:0] trim1_o,
  output logic [7:0] trim2_o,
  output logic [7:0] trim3_o,
  output logic       wr_stb_o,
  output logic       frame_err_o
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_meta, mosi_s;
  logic unused;

  spi_sync #(.RST_VAL(1'b0)) u_sclk (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(sclk_i),
    .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_cs (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(cs_n_i),
    .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  assign unused = sclk_lvl;

  spi_state_t state, state_nx;
  logic [4:0] bit_cnt;
  logic [6:0] sr;
  logic [7:0] cmd, tx, rd_data, data;
  logic [6:0] rd_addr;
  logic [1:0] warm;
  logic armed, miso_q, wr_stb, frame_err;
  logic start, shift_rise, cmd_done, frame_done;
  logic abort, drive_miso, commit;
  logic [7:0] thres, slope, gain, trim1, trim2, trim3;
  logic [4:0] ctrl;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:    if (start) state_nx = ST_CMD;
      ST_CMD: begin
        if (abort)         state_nx = ST_IDLE;
        else if (cmd_done) state_nx = ST_DATA;
      end
      ST_DATA: begin
        if (abort)           state_nx = ST_IDLE;
        else if (frame_done) state_nx = ST_WAIT_CS;
      end
      ST_WAIT_CS: if (cs_rise) state_nx = ST_IDLE;
    endcase
  end

  // A frame may only open on a cs_n fall seen after cs_n was high post-reset
  always_comb begin
    start      = (state == ST_IDLE) & cs_fall & armed;
    shift_rise = ((state == ST_CMD) | (state == ST_DATA))
               & sclk_rise & ~cs_s;
    cmd_done   = (state == ST_CMD) & shift_rise
               & (bit_cnt == LAST_CMD_BIT);
    frame_done = (state == ST_DATA) & shift_rise
               & (bit_cnt == LAST_BIT);
    abort      = ((state == ST_CMD) | (state == ST_DATA)) & cs_rise;
    drive_miso = (state == ST_DATA) & sclk_fall & ~cs_s;
  end

  assign rd_addr = {sr[5:0], mosi_s};
  assign data    = {sr, mosi_s};
  assign commit  = frame_done & ~cmd[7] & is_writable(cmd[6:0]);

  always_comb begin
    rd_data = 8'h00;
    unique case (rd_addr)
      ADDR_THRES: rd_data = thres;
      ADDR_SLOPE: rd_data = slope;
      ADDR_GAIN:  rd_data = gain;
      ADDR_CTRL:  rd_data = {3'b000, ctrl};
      ADDR_TRIM1: rd_data = trim1;
      ADDR_TRIM2: rd_data = trim2;
      ADDR_TRIM3: rd_data = trim3;
      ADDR_ID:    rd_data = ID_VALUE;
      default:    rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
      warm      <= 2'b00;
      armed     <= 1'b0;
      bit_cnt   <= 5'd0;
      sr        <= 7'd0;
      cmd       <= 8'h00;
      tx        <= 8'h00;
      miso_q    <= 1'b0;
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mosi_meta <= mosi_i;
      mosi_s    <= mosi_meta;
      warm      <= {warm[0], 1'b1};
      if (warm[1] & cs_s) armed <= 1'b1;
      wr_stb    <= commit;
      frame_err <= abort;
      if (start) begin
        bit_cnt <= 5'd0;
        sr      <= 7'd0;
      end else if (shift_rise) begin
        sr <= {sr[5:0], mosi_s};
        if (bit_cnt != MAX_BITS) bit_cnt <= bit_cnt + 5'd1;
      end
      if (cmd_done) begin
        cmd <= data;
        tx  <= rd_data;
      end
      if (drive_miso) begin
        miso_q <= tx[7];
        tx     <= {tx[6:0], 1'b0};
      end else if (state != ST_DATA) begin
        miso_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      thres <= RST_THRES;
      slope <= RST_SLOPE;
      gain  <= RST_GAIN;
      ctrl  <= RST_CTRL;
      trim1 <= RST_TRIM;
      trim2 <= RST_TRIM;
      trim3 <= RST_TRIM;
    end else if (commit) begin
      unique case (cmd[6:0])
        ADDR_THRES: thres <= data;
        ADDR_SLOPE: slope <= data;
        ADDR_GAIN:  gain  <= data;
        ADDR_CTRL:  ctrl  <= data[4:0];
        ADDR_TRIM1: trim1 <= data;
        ADDR_TRIM2: trim2 <= data;
        ADDR_TRIM3: trim3 <= data;
        default: ;
      endcase
    end
  end

  assign miso_o      = miso_q;
  assign miso_oeb_o  = cs_s;
  assign wr_stb_o    = wr_stb;
  assign frame_err_o = frame_err;
  assign thres_o     = thres;
  assign slope_o     = slope;
  assign gain_o      = gain;
  assign ctrl_o      = ctrl;
  assign trim1_o     = trim1;
  assign trim2_o     = trim2;
  assign trim3_o     = trim3;

endmodule
